// File: rtl/fcvt_pkg.sv
// Shared definitions for the float/int converters: rounding modes, float classes
// and the saturation values used when a conversion is invalid.
package fcvt_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [2:0] {
        FC_ZERO,
        FC_SUB,
        FC_NORM,
        FC_INF,
        FC_NAN
    } fclass_e;

    // Returned 64 bits wide; callers truncate to their integer width.
    function automatic logic [63:0] sat_value(input logic is_uns, input logic neg,
                                              input int unsigned int_w);
        logic [63:0] v;
        if (is_uns) begin
            v = neg ? 64'd0 : (64'd1 << int_w) - 64'd1;
        end else begin
            v = (64'd1 << (int_w - 1)) - 64'd1;
            if (neg) v = ~v;
        end
        return v;
    endfunction

endpackage

// File: rtl/fcvt_f2i_pipe_if.sv
// Operand/result handshake bundle of the float-to-integer converter.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the source keeps its payload and valid stable until that transfer.
interface fcvt_f2i_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32,
    parameter int TAG_W = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+MAN_W:0]   in_a;
    logic [2:0]             in_frm;
    logic                   in_unsigned;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [INT_W-1:0]       out_d;
    logic                   out_invalid;
    logic                   out_inexact;
    logic [TAG_W-1:0]       out_tag;

    modport master (
        output in_valid, in_a, in_frm, in_unsigned, in_tag, out_ready,
        input  in_ready, out_valid, out_d, out_invalid, out_inexact, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_frm, in_unsigned, in_tag, out_ready,
        output in_ready, out_valid, out_d, out_invalid, out_inexact, out_tag
    );
endinterface

// File: rtl/fcvt_round.sv
// Rounding increment decision on a sign/magnitude value; shared by the f2i and f2f converters.
module fcvt_round
    import fcvt_pkg::*;
(
    input  logic [2:0] i_frm,
    input  logic       i_sign,
    input  logic       i_lsb,
    input  logic       i_guard,
    input  logic       i_sticky,
    output logic       o_inc
);
    // Reserved encodings fall into the default branch and truncate like RTZ.
    always_comb begin
        o_inc = 1'b0;
        case (i_frm)
            RM_RNE:  o_inc = i_guard & (i_sticky | i_lsb);
            RM_RDN:  o_inc = i_sign & (i_guard | i_sticky);
            RM_RUP:  o_inc = ~i_sign & (i_guard | i_sticky);
            RM_RMM:  o_inc = i_guard;
            default: o_inc = 1'b0;
        endcase
    end
endmodule

// File: rtl/fcvt_f2i_pipe.sv
// Three-stage float-to-integer converter (classify, align, round/range) with a
// single global stall; results carry the caller tag and RISC-V NV/NX flags.
module fcvt_f2i_pipe
    import fcvt_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int INT_W = 32,
    parameter int TAG_W = 5
) (
    input logic            clk,
    input logic            rst,
    fcvt_f2i_pipe_if.slave bus
);
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int SH_W  = $clog2(INT_W + 1);
    localparam int SIG_W = MAN_W + 1;
    localparam int FB    = MAN_W + 1;
    localparam int XW    = INT_W + 1 + FB;
    localparam logic [INT_W:0] MAX_POS_S = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic [INT_W:0] MAX_NEG_S = {2'b01, {(INT_W-1){1'b0}}};

    logic w_en;
    logic r_out_valid;
    assign w_en         = ~r_out_valid | bus.out_ready;
    assign bus.in_ready = w_en;

    // Stage 1: classify
    logic             w_sign;
    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_frac;
    fclass_e          w_cls;
    int               w_e;
    logic             w_big, w_tiny;
    assign {w_sign, w_exp, w_frac} = bus.in_a;

    always_comb begin
        w_cls = FC_NORM;
        if (w_exp == '0)      w_cls = (w_frac == '0) ? FC_ZERO : FC_SUB;
        else if (w_exp == '1) w_cls = (w_frac == '0) ? FC_INF : FC_NAN;
        w_e    = (w_exp == '0) ? (1 - BIAS) : (int'(w_exp) - BIAS);
        w_big  = (w_cls == FC_INF) || ((w_cls == FC_NORM) && (w_e >= INT_W));
        w_tiny = (w_e < -1);
    end

    logic             r1_valid, r1_sign, r1_uns, r1_big, r1_tiny;
    logic [2:0]       r1_frm;
    logic [TAG_W-1:0] r1_tag;
    fclass_e          r1_cls;
    logic [SIG_W-1:0] r1_sig;
    logic [SH_W-1:0]  r1_sh;

    // Stage 2: align so the value is scaled by 2^FB; guard is the first fraction bit.
    logic [XW-1:0]    w_x;
    logic [INT_W:0]   w_mag;
    logic             w_guard, w_sticky;
    always_comb begin
        w_x      = XW'(r1_sig) << r1_sh;
        w_mag    = r1_tiny ? '0 : w_x[XW-1:FB];
        w_guard  = r1_tiny ? 1'b0 : w_x[FB-1];
        w_sticky = r1_tiny ? (|r1_sig) : (|w_x[FB-2:0]);
    end

    logic             r2_valid, r2_sign, r2_uns, r2_big, r2_nan, r2_guard, r2_sticky;
    logic [2:0]       r2_frm;
    logic [TAG_W-1:0] r2_tag;
    logic [INT_W:0]   r2_mag;

    // Stage 3: round, range-check, saturate
    logic             w_inc, w_in_range, w_invalid, w_nx;
    logic [INT_W:0]   w_m;
    logic [INT_W-1:0] w_sat, w_res, w_d;

    fcvt_round u_round (
        .i_frm    (r2_frm),
        .i_sign   (r2_sign),
        .i_lsb    (r2_mag[0]),
        .i_guard  (r2_guard),
        .i_sticky (r2_sticky),
        .o_inc    (w_inc)
    );

    always_comb begin
        w_m = r2_mag + (INT_W+1)'(w_inc);
        if (r2_uns) w_in_range = r2_sign ? (w_m == '0) : ~w_m[INT_W];
        else        w_in_range = r2_sign ? (w_m <= MAX_NEG_S) : (w_m <= MAX_POS_S);
        w_invalid = r2_nan | r2_big | ~w_in_range;
        w_sat     = INT_W'(sat_value(r2_uns, r2_sign & ~r2_nan, INT_W));
        w_res     = r2_sign ? -w_m[INT_W-1:0] : w_m[INT_W-1:0];
        w_d       = w_invalid ? w_sat : w_res;
        w_nx      = ~w_invalid & (r2_guard | r2_sticky);
    end

    logic [INT_W-1:0] r_out_d;
    logic             r_out_nv, r_out_nx;
    logic [TAG_W-1:0] r_out_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r2_valid    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_d     <= '0;
            r_out_nv    <= 1'b0;
            r_out_nx    <= 1'b0;
            r_out_tag   <= '0;
        end else if (w_en) begin
            r1_valid    <= bus.in_valid;
            r2_valid    <= r1_valid;
            r_out_valid <= r2_valid;
            if (r2_valid) begin
                r_out_d   <= w_d;
                r_out_nv  <= w_invalid;
                r_out_nx  <= w_nx;
                r_out_tag <= r2_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r1_sign   <= w_sign;
            r1_uns    <= bus.in_unsigned;
            r1_frm    <= bus.in_frm;
            r1_tag    <= bus.in_tag;
            r1_cls    <= w_cls;
            r1_big    <= w_big;
            r1_tiny   <= w_tiny;
            r1_sig    <= {(w_exp != '0), w_frac};
            r1_sh     <= SH_W'(w_e + 1);
            r2_sign   <= r1_sign;
            r2_uns    <= r1_uns;
            r2_frm    <= r1_frm;
            r2_tag    <= r1_tag;
            r2_big    <= r1_big;
            r2_nan    <= (r1_cls == FC_NAN);
            r2_mag    <= w_mag;
            r2_guard  <= w_guard;
            r2_sticky <= w_sticky;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_d       = r_out_d;
    assign bus.out_invalid = r_out_nv;
    assign bus.out_inexact = r_out_nx;
    assign bus.out_tag     = r_out_tag;
endmodule

// File: tb/tb_fcvt_f2i_pipe.sv
// Directed bench for fcvt_f2i_pipe: single conversions with hand-computed results,
// a backpressured tagged stream and a mid-stream reset.
module tb_fcvt_f2i_pipe;
    import fcvt_pkg::*;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int INT_W = 32;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fcvt_f2i_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .INT_W(INT_W), .TAG_W(TAG_W)) bus ();

    fcvt_f2i_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .INT_W(INT_W), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [TAG_W+INT_W-1:0] exp_q[$];
    logic [TAG_W-1:0] next_tag = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated conversion: latency, result, flags and tag.
    task automatic run_one(input string name, input logic [31:0] a, input logic [2:0] frm,
                           input logic uns, input logic [31:0] ed, input logic env,
                           input logic enx);
        int cycles;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_a        = a;
        bus.in_frm      = frm;
        bus.in_unsigned = uns;
        bus.in_tag      = next_tag;
        bus.out_ready   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cycles = 1;
        while (bus.out_valid !== 1'b1 && cycles < 10) begin
            @(negedge clk);
            cycles++;
        end
        check({name, "_lat"}, 64'(cycles), 64'd3);
        check({name, "_d"},   64'(bus.out_d), 64'(ed));
        check({name, "_nv"},  64'(bus.out_invalid), 64'(env));
        check({name, "_nx"},  64'(bus.out_inexact), 64'(enx));
        check({name, "_tag"}, 64'(bus.out_tag), 64'(next_tag));
        next_tag = next_tag + 1'b1;
    endtask

    logic [31:0] bp_a[8] = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h40800000,
                             32'h40A00000, 32'hC0C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] bp_d[8] = '{32'd1, 32'd2, 32'hFFFFFFFD, 32'd4,
                             32'd5, 32'hFFFFFFFA, 32'd7, 32'd8};

    initial begin
        int acc, got, cyc, seen;
        logic pv, pr;
        logic [INT_W-1:0] pd;
        logic [TAG_W-1:0] pt;
        logic [TAG_W+INT_W-1:0] e;

        bus.in_valid    = 1'b0;
        bus.in_a        = '0;
        bus.in_frm      = RM_RNE;
        bus.in_unsigned = 1'b0;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_d",     64'(bus.out_d), 64'd0);
        check("rst_out_nv",    64'(bus.out_invalid), 64'd0);
        check("rst_out_nx",    64'(bus.out_inexact), 64'd0);
        check("rst_out_tag",   64'(bus.out_tag), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready), 64'd1);

        run_one("rne_2p5",     32'h40200000, RM_RNE, 1'b0, 32'd2,        1'b0, 1'b1);
        run_one("rne_m3p5",    32'hC0600000, RM_RNE, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b1);
        run_one("rne_3p0",     32'h40400000, RM_RNE, 1'b0, 32'd3,        1'b0, 1'b0);
        run_one("rne_m2p5",    32'hC0200000, RM_RNE, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1);
        run_one("rne_0p5",     32'h3F000000, RM_RNE, 1'b0, 32'd0,        1'b0, 1'b1);
        run_one("rmm_0p5",     32'h3F000000, RM_RMM, 1'b0, 32'd1,        1'b0, 1'b1);
        run_one("frm5_1p5",    32'h3FC00000, 3'b101, 1'b0, 32'd1,        1'b0, 1'b1);
        run_one("neg_zero",    32'h80000000, RM_RNE, 1'b0, 32'd0,        1'b0, 1'b0);
        run_one("s_3e9",       32'h4F32D05E, RM_RNE, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
        run_one("s_min",       32'hCF000000, RM_RNE, 1'b0, 32'h80000000, 1'b0, 1'b0);
        run_one("s_2p31",      32'h4F000000, RM_RNE, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
        run_one("s_nan",       32'h7FC00000, RM_RNE, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
        run_one("s_ninf",      32'hFF800000, RM_RNE, 1'b0, 32'h80000000, 1'b1, 1'b0);
        run_one("u_m1",        32'hBF800000, RM_RNE, 1'b1, 32'd0,        1'b1, 1'b0);
        run_one("u_m0p3_rtz",  32'hBE99999A, RM_RTZ, 1'b1, 32'd0,        1'b0, 1'b1);
        run_one("u_3e9",       32'h4F32D05E, RM_RNE, 1'b1, 32'hB2D05E00, 1'b0, 1'b0);
        run_one("u_2p32",      32'h4F800000, RM_RNE, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_one("u_pinf",      32'h7F800000, RM_RNE, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_one("u_negnan",    32'hFFC00000, RM_RNE, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        run_one("u_max_rup",   32'h4F7FFFFF, RM_RUP, 1'b1, 32'hFFFFFF00, 1'b0, 1'b0);
        run_one("rup_1p1",     32'h3F8CCCCD, RM_RUP, 1'b0, 32'd2,        1'b0, 1'b1);
        run_one("rdn_m1p1",    32'hBF8CCCCD, RM_RDN, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1);
        run_one("rup_subn",    32'h00000001, RM_RUP, 1'b0, 32'd1,        1'b0, 1'b1);
        run_one("rdn_nsubn",   32'h80000001, RM_RDN, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
        run_one("rup_2p31m",   32'h4EFFFFFF, RM_RUP, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0);

        // Backpressured stream of 8 tagged operations with random out_ready.
        acc = 0; got = 0; cyc = 0;
        pv = 1'b0; pr = 1'b0; pd = '0; pt = '0;
        bus.in_frm      = RM_RNE;
        bus.in_unsigned = 1'b0;
        while (got < 8 && cyc < 400) begin
            @(negedge clk);
            if (pv && !pr) begin
                check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                check("bp_hold_d",     64'(bus.out_d), 64'(pd));
                check("bp_hold_tag",   64'(bus.out_tag), 64'(pt));
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            if (acc < 8) begin
                bus.in_valid = 1'b1;
                bus.in_a     = bp_a[acc];
                bus.in_tag   = TAG_W'(acc + 8);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("bp_d",   64'(bus.out_d), 64'(e[INT_W-1:0]));
                    check("bp_tag", 64'(bus.out_tag), 64'(e[TAG_W+INT_W-1:INT_W]));
                end else begin
                    check("bp_unexpected_result", 64'd1, 64'd0);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({TAG_W'(acc + 8), bp_d[acc]});
                acc++;
            end
            pv = bus.out_valid;
            pr = bus.out_ready;
            pd = bus.out_d;
            pt = bus.out_tag;
            cyc++;
        end
        check("bp_received", 64'(got), 64'd8);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("bp_no_extra", 64'(seen), 64'd0);

        // Reset with three operations in flight.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = 32'h3F800000;
            bus.in_tag   = TAG_W'(20 + i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_in_ready",  64'(bus.in_ready), 64'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst_mid_no_stale", 64'(seen), 64'd0);

        run_one("post_rst_3p0", 32'h40400000, RM_RNE, 1'b0, 32'd3, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
